// File: rtl/panel_bus_master.sv
// Front-panel bus initiator: runs EXAMINE / DEPOSIT cycles directly on the
// memory bus while the CPU is paused and latches the read-back byte.
module panel_bus_master #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic        examine_pulse,
  input  logic        examine_next_pulse,
  input  logic        deposit_pulse,
  input  logic        deposit_next_pulse,
  input  logic [15:0] addr_sw,
  input  logic [7:0]  data_sw,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        mem_rd,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] addr_leds,
  output logic [7:0]  data_leds,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, REQ, WRITE, READ, WAIT, DONE} state_t;

  localparam logic [1:0] LAST_WAIT = 2'(RD_LATENCY - 1);

  state_t      state;
  logic        op_write;
  logic [15:0] addr_reg;
  logic [7:0]  data_reg;
  logic [7:0]  wdata_reg;
  logic [1:0]  wait_cnt;
  logic        bus_req_q;
  logic        we_q;
  logic        rd_q;
  logic        busy_q;

  logic any_cmd;
  logic abort;

  assign any_cmd = examine_pulse | examine_next_pulse | deposit_pulse | deposit_next_pulse;
  assign abort   = !bus_gnt || !pause;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_write  <= 1'b0;
      addr_reg  <= 16'h0000;
      data_reg  <= 8'h00;
      wdata_reg <= 8'h00;
      wait_cnt  <= 2'd0;
      bus_req_q <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      rd_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pause && any_cmd) begin
            state     <= REQ;
            bus_req_q <= 1'b1;
            busy_q    <= 1'b1;
            if (examine_pulse) begin
              addr_reg <= addr_sw;
              op_write <= 1'b0;
            end else if (examine_next_pulse) begin
              addr_reg <= addr_reg + 16'd1;
              op_write <= 1'b0;
            end else if (deposit_pulse) begin
              wdata_reg <= data_sw;
              op_write  <= 1'b1;
            end else begin
              addr_reg  <= addr_reg + 16'd1;
              wdata_reg <= data_sw;
              op_write  <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus_gnt) begin
            if (op_write) begin
              state <= WRITE;
              we_q  <= 1'b1;
            end else begin
              state <= READ;
              rd_q  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            state     <= IDLE;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            state <= READ;
            rd_q  <= 1'b1;
          end
        end
        READ: begin
          if (abort) begin
            state     <= IDLE;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            state    <= WAIT;
            wait_cnt <= 2'd0;
          end
        end
        WAIT: begin
          if (abort) begin
            state     <= IDLE;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (wait_cnt == LAST_WAIT) begin
            data_reg  <= mem_rdata;
            state     <= DONE;
            bus_req_q <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bus_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are qualified by the live grant so a dropped grant can never
  // leave a strobe on the bus for the cycle it takes the FSM to notice.
  assign mem_we    = we_q & bus_gnt;
  assign mem_rd    = rd_q & bus_gnt;
  assign bus_req   = bus_req_q;
  assign busy      = busy_q;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign addr_leds = addr_reg;
  assign data_leds = data_reg;

endmodule

// File: tb/tb_panel_bus_master.sv
// Bench for panel_bus_master: directed panel scenarios with literal values,
// then randomized traffic checked every cycle against a timeline model.
module tb_panel_bus_master;

  localparam int RD_LATENCY = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pause = 1'b1;
  logic        examine_pulse = 1'b0;
  logic        examine_next_pulse = 1'b0;
  logic        deposit_pulse = 1'b0;
  logic        deposit_next_pulse = 1'b0;
  logic [15:0] addr_sw = 16'h0000;
  logic [7:0]  data_sw = 8'h00;
  logic        bus_gnt = 1'b1;
  logic [7:0]  mem_rdata;
  logic        bus_req, mem_we, mem_rd, busy;
  logic [15:0] mem_addr, addr_leds;
  logic [7:0]  mem_wdata, data_leds;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  panel_bus_master #(.RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .reset(reset), .pause(pause),
    .examine_pulse(examine_pulse), .examine_next_pulse(examine_next_pulse),
    .deposit_pulse(deposit_pulse), .deposit_next_pulse(deposit_next_pulse),
    .addr_sw(addr_sw), .data_sw(data_sw), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_rd(mem_rd), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .addr_leds(addr_leds), .data_leds(data_leds), .busy(busy)
  );

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    if (a == 16'h0123) return 8'hC3;
    return 8'(a * 16'd7) + a[15:8];
  endfunction

  // Sync RAM seen by the DUT, with a read pipeline of RD_LATENCY stages
  logic [7:0] ram [logic [15:0]];
  logic [7:0] rd_pipe [0:RD_LATENCY-1];
  assign mem_rdata = rd_pipe[RD_LATENCY-1];

  function automatic logic [7:0] ram_read(input logic [15:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] = mem_wdata;
    rd_pipe[0] <= mem_rd ? ram_read(mem_addr) : 8'($urandom);
    for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Timeline model: a command is pending until granted, then walks an
  // elapsed-cycle index m_e from the first strobe to the capture point.
  bit          m_active = 0, m_granted = 0, m_done = 0, m_write = 0;
  int          m_e = 0;
  logic [15:0] m_addr = 16'h0000;
  logic [7:0]  m_data = 8'h00, m_wdata = 8'h00;
  logic [7:0]  mirror [logic [15:0]];

  function automatic logic [7:0] mirror_read(input logic [15:0] a);
    return mirror.exists(a) ? mirror[a] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_granted = 0; m_done = 0;
      m_addr = 16'h0000; m_data = 8'h00; m_wdata = 8'h00;
    end else if (!m_active) begin
      if (pause && (examine_pulse || examine_next_pulse || deposit_pulse || deposit_next_pulse)) begin
        m_active = 1; m_granted = 0; m_done = 0;
        if (examine_pulse) begin
          m_write = 0; m_addr = addr_sw;
        end else if (examine_next_pulse) begin
          m_write = 0; m_addr = m_addr + 16'd1;
        end else if (deposit_pulse) begin
          m_write = 1; m_wdata = data_sw;
        end else begin
          m_write = 1; m_addr = m_addr + 16'd1; m_wdata = data_sw;
        end
      end
    end else if (m_done) begin
      m_active = 0;
    end else if (!m_granted) begin
      if (bus_gnt) begin
        m_granted = 1; m_e = 0;
      end
    end else begin
      if (m_write && m_e == 0 && bus_gnt) mirror[m_addr] = m_wdata;
      if (!bus_gnt || !pause) m_active = 0;
      else if (m_e == RD_LATENCY + (m_write ? 1 : 0)) begin
        m_data = mirror_read(m_addr);
        m_done = 1;
      end else m_e++;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      if (errors <= 30)
        $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic compare_all();
    bit post, exp_we, exp_rd;
    post   = m_active && m_granted && !m_done;
    exp_we = post && m_write && m_e == 0 && bus_gnt;
    exp_rd = post && (m_e == (m_write ? 1 : 0)) && bus_gnt;
    check_output("busy", 32'(busy), 32'(m_active));
    check_output("bus_req", 32'(bus_req), 32'(m_active && !m_done));
    check_output("mem_we", 32'(mem_we), 32'(exp_we));
    check_output("mem_rd", 32'(mem_rd), 32'(exp_rd));
    check_output("mem_addr", 32'(mem_addr), 32'(m_addr));
    check_output("addr_leds", 32'(addr_leds), 32'(m_addr));
    check_output("data_leds", 32'(data_leds), 32'(m_data));
    check_output("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    check_output("we_rd_exclusive", 32'(mem_we & mem_rd), 32'd0);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] which);
    examine_pulse      = which[0];
    examine_next_pulse = which[1];
    deposit_pulse      = which[2];
    deposit_next_pulse = which[3];
    tick();
    examine_pulse      = 1'b0;
    examine_next_pulse = 1'b0;
    deposit_pulse      = 1'b0;
    deposit_next_pulse = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check_output("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick();
    check_output("reset_addr_leds", 32'(addr_leds), 32'h0);
    check_output("reset_data_leds", 32'(data_leds), 32'h0);
    check_output("reset_busy", 32'(busy), 32'h0);
    check_output("reset_bus_req", 32'(bus_req), 32'h0);
    reset = 1'b0;
    tick();

    // Examine 0x0123 holding 0xC3
    addr_sw = 16'h0123;
    apply_stimulus(4'b0001);
    check_output("ex_bus_req", 32'(bus_req), 32'h1);
    tick();
    check_output("ex_mem_rd", 32'(mem_rd), 32'h1);
    check_output("ex_mem_addr", 32'(mem_addr), 32'h0123);
    repeat (RD_LATENCY + 1) tick();
    check_output("ex_data_leds", 32'(data_leds), 32'hC3);
    check_output("ex_addr_leds", 32'(addr_leds), 32'h0123);
    check_output("ex_busy_done", 32'(busy), 32'h1);
    tick();
    check_output("ex_busy_low", 32'(busy), 32'h0);

    // Deposit then deposit-next
    addr_sw = 16'h0010;
    apply_stimulus(4'b0001);
    wait_idle(64);
    data_sw = 8'h3E;
    apply_stimulus(4'b0100);
    tick();
    check_output("dep_mem_we", 32'(mem_we), 32'h1);
    check_output("dep_mem_addr", 32'(mem_addr), 32'h0010);
    check_output("dep_mem_wdata", 32'(mem_wdata), 32'h3E);
    tick();
    check_output("dep_readback_rd", 32'(mem_rd), 32'h1);
    wait_idle(64);
    check_output("dep_data_leds", 32'(data_leds), 32'h3E);
    data_sw = 8'h55;
    apply_stimulus(4'b1000);
    wait_idle(64);
    check_output("depn_addr_leds", 32'(addr_leds), 32'h0011);
    check_output("depn_data_leds", 32'(data_leds), 32'h55);

    // Address wrap on examine-next
    addr_sw = 16'hFFFF;
    apply_stimulus(4'b0001);
    wait_idle(64);
    apply_stimulus(4'b0010);
    tick();
    check_output("wrap_mem_addr", 32'(mem_addr), 32'h0000);
    check_output("wrap_mem_rd", 32'(mem_rd), 32'h1);
    wait_idle(64);
    check_output("wrap_addr_leds", 32'(addr_leds), 32'h0000);

    // Delayed grant, then grant dropped during WAIT
    bus_gnt = 1'b0;
    addr_sw = 16'h0123;
    apply_stimulus(4'b0001);
    for (int i = 0; i < 5; i++) begin
      check_output("gnt_hold_req", 32'(bus_req), 32'h1);
      check_output("gnt_hold_no_rd", 32'(mem_rd), 32'h0);
      tick();
    end
    bus_gnt = 1'b1;
    tick();
    check_output("gnt_late_rd", 32'(mem_rd), 32'h1);
    tick();
    bus_gnt = 1'b0;
    tick();
    check_output("abort_busy", 32'(busy), 32'h0);
    check_output("abort_bus_req", 32'(bus_req), 32'h0);
    check_output("abort_data_kept", 32'(data_leds), 32'(init_byte(16'h0000)));
    bus_gnt = 1'b1;
    tick();

    // Commands ignored while running
    pause = 1'b0;
    apply_stimulus(4'b0001);
    check_output("run_no_req", 32'(bus_req), 32'h0);
    tick();
    check_output("run_no_busy", 32'(busy), 32'h0);
    pause = 1'b1;
    tick();

    // Simultaneous examine + deposit: examine wins
    addr_sw = 16'h0200;
    data_sw = 8'hAA;
    apply_stimulus(4'b0101);
    tick();
    check_output("prio_rd", 32'(mem_rd), 32'h1);
    check_output("prio_no_we", 32'(mem_we), 32'h0);
    wait_idle(64);
    check_output("prio_data_leds", 32'(data_leds), 32'(init_byte(16'h0200)));

    // Pulse while busy is dropped
    addr_sw = 16'h0300;
    apply_stimulus(4'b0001);
    data_sw = 8'h77;
    addr_sw = 16'h0400;
    apply_stimulus(4'b0100);
    wait_idle(64);
    check_output("busy_drop_addr", 32'(addr_leds), 32'h0300);
    check_output("busy_drop_data", 32'(data_leds), 32'(init_byte(16'h0300)));
    check_output("busy_drop_wdata", 32'(mem_wdata), 32'h55);

    // Reset during WAIT of a deposit
    data_sw = 8'h99;
    apply_stimulus(4'b0100);
    repeat (3) tick();
    check_output("rst_wait_req", 32'(bus_req), 32'h1);
    reset = 1'b1;
    tick();
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_bus_req", 32'(bus_req), 32'h0);
    check_output("rst_strobes", 32'({mem_we, mem_rd}), 32'h0);
    check_output("rst_addr_leds", 32'(addr_leds), 32'h0);
    check_output("rst_data_leds", 32'(data_leds), 32'h0);
    reset = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      pause              = ($urandom_range(0, 15) != 0);
      bus_gnt            = ($urandom_range(0, 7) != 0);
      examine_pulse      = ($urandom_range(0, 9) == 0);
      examine_next_pulse = ($urandom_range(0, 9) == 0);
      deposit_pulse      = ($urandom_range(0, 9) == 0);
      deposit_next_pulse = ($urandom_range(0, 9) == 0);
      addr_sw            = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
      data_sw            = 8'($urandom);
      reset              = ($urandom_range(0, 399) == 0);
      tick();
    end
    examine_pulse = 1'b0; examine_next_pulse = 1'b0;
    deposit_pulse = 1'b0; deposit_next_pulse = 1'b0;
    reset = 1'b0; pause = 1'b1; bus_gnt = 1'b1;
    tick();
    wait_idle(64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/panel_bus_master.md
Name: panel_bus_master

Overview:
- Front-panel bus initiator for the Altair core: performs EXAMINE, EXAMINE NEXT, DEPOSIT and DEPOSIT NEXT by driving the memory bus directly while the CPU is paused.
- This replaces jam-feeding opcodes to the CPU.
- Requests the bus from the top level (which holds CPU ce low while granted), issues sync-RAM write/read strobes, and latches the read-back byte for the panel LEDs.
- Sits between the debounced panel pushbuttons and the memory address decode.

Parameters:
- RD_LATENCY, 1, cycles from mem_rd strobe to valid mem_rdata (legal 1..4).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pause  input  1  run/stop switch; 1 = stopped, panel commands allowed
- examine_pulse  input  1  one-cycle pulse from debouncer (press edge)
- examine_next_pulse  input  1  one-cycle pulse
- deposit_pulse  input  1  one-cycle pulse
- deposit_next_pulse  input  1  one-cycle pulse
- addr_sw  input  16  address switches
- data_sw  input  8  data switches
- bus_req  output  1  request memory bus
- bus_gnt  input  1  grant; CPU is held while high
- mem_addr  output  16  memory address (always equals addr_reg)
- mem_we  output  1  write strobe, one cycle
- mem_rd  output  1  read strobe, one cycle
- mem_wdata  output  8  write data
- mem_rdata  input  8  read data from address decode mux
- addr_leds  output  16  current panel address (addr_reg)
- data_leds  output  8  last read-back byte
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (overrides everything, including mid-operation):
  - state=IDLE; addr_reg=0; data_reg=0; wdata_reg=0.
  - bus_req=0, mem_we=0, mem_rd=0, busy=0.
  - addr_leds=0, data_leds=0.
- States: IDLE, REQ, WRITE, READ, WAIT, DONE.
- Command acceptance:
  - Commands are accepted only in IDLE with pause=1. Pulses at any other time are dropped, not queued.
  - Priority when several pulses arrive in the same cycle: examine > examine_next > deposit > deposit_next. The losers are dropped.
- On acceptance (IDLE -> REQ):
  - examine: addr_reg<=addr_sw; op=read.
  - examine_next: addr_reg<=addr_reg+1, 16-bit wrap (FFFF->0000); op=read.
  - deposit: addr_reg unchanged; wdata_reg<=data_sw; op=write.
  - deposit_next: addr_reg<=addr_reg+1 with wrap; wdata_reg<=data_sw; op=write.
- REQ:
  - bus_req=1; wait for bus_gnt=1 (no timeout).
  - Then go to WRITE if op=write, else READ.
- WRITE: mem_we=1 for exactly one cycle; mem_wdata=wdata_reg; -> READ (read-back).
- READ: mem_rd=1 for exactly one cycle; -> WAIT.
- WAIT:
  - Lasts RD_LATENCY cycles, counted by an internal counter.
  - On the last WAIT cycle, data_reg<=mem_rdata; -> DONE.
- DONE: bus_req=0; -> IDLE.
- bus_req stays high from REQ through WAIT inclusive.
- Abort condition: bus_gnt=0 or pause=0 in WRITE, READ or WAIT.
  - Next cycle goes to IDLE with all strobes and bus_req low.
  - data_reg is unchanged; addr_reg keeps its updated value.
  - A write already strobed is not undone.
- mem_we and mem_rd are never high together, and never high without bus_gnt.
- Outputs: addr_leds=addr_reg, data_leds=data_reg, both registered.
- Timing with bus_gnt tied high and RD_LATENCY=1, pulse in cycle N:
  - examine: mem_rd in N+2; data_leds updated in N+4; busy low from N+5.
  - deposit: mem_we in N+2; mem_rd in N+3; data_leds updated in N+5; busy low from N+6.
- Each extra RD_LATENCY cycle and each cycle of grant delay adds one cycle to these figures.

Test Plan:
- Examine, pause=1, gnt tied 1, addr_sw=0x0123, RAM[0x0123]=0xC3, pulse examine -> mem_rd in N+2 with mem_addr=0x0123; data_leds=0xC3 at N+4; addr_leds=0x0123.
- Deposit/deposit_next: after examine at 0x0010, data_sw=0x3E, pulse deposit -> one mem_we at 0x0010 with wdata 0x3E, data_leds=0x3E. Then data_sw=0x55, pulse deposit_next -> write 0x55 at 0x0011; addr_leds=0x0011; data_leds=0x55.
- Wrap-around: examine 0xFFFF then examine_next -> mem_addr=0x0000, addr_leds=0x0000.
- Grant handshake: hold bus_gnt=0 for 5 cycles after bus_req -> no strobes during that time; read proceeds 1 cycle after gnt rises. Drop gnt during WAIT -> IDLE, data_leds unchanged.
- Gating and priority:
  - pause=0 with examine pulse -> bus_req never asserts.
  - Simultaneous examine+deposit pulses -> only the read occurs, no mem_we.
  - Pulse while busy -> ignored.
- Reset during WAIT of a deposit -> next cycle all outputs 0, state IDLE. RD_LATENCY=3 build: examine data_leds update at N+6.
